// File: rtl/stump_pkg.sv
// Shared Stump ISA constants: FSM state encodings, opcodes and branch condition codes.
package stump_pkg;

   // Control FSM state encodings (also visible on the state output)
   localparam logic [1:0] StFetch   = 2'b00;
   localparam logic [1:0] StExecute = 2'b01;
   localparam logic [1:0] StMemory  = 2'b10;

   // Opcodes, ir[15:13]
   localparam logic [2:0] OpAdd  = 3'b000;
   localparam logic [2:0] OpAdc  = 3'b001;
   localparam logic [2:0] OpSub  = 3'b010;
   localparam logic [2:0] OpSbc  = 3'b011;
   localparam logic [2:0] OpAnd  = 3'b100;
   localparam logic [2:0] OpOr   = 3'b101;
   localparam logic [2:0] OpLdSt = 3'b110;
   localparam logic [2:0] OpBcc  = 3'b111;

   // Branch conditions, ir[11:8]
   localparam logic [3:0] CondAl = 4'h0;
   localparam logic [3:0] CondNv = 4'h1;
   localparam logic [3:0] CondHi = 4'h2;
   localparam logic [3:0] CondLs = 4'h3;
   localparam logic [3:0] CondCc = 4'h4;
   localparam logic [3:0] CondCs = 4'h5;
   localparam logic [3:0] CondNe = 4'h6;
   localparam logic [3:0] CondEq = 4'h7;
   localparam logic [3:0] CondVc = 4'h8;
   localparam logic [3:0] CondVs = 4'h9;
   localparam logic [3:0] CondPl = 4'hA;
   localparam logic [3:0] CondMi = 4'hB;
   localparam logic [3:0] CondGe = 4'hC;
   localparam logic [3:0] CondLt = 4'hD;
   localparam logic [3:0] CondGt = 4'hE;
   localparam logic [3:0] CondLe = 4'hF;

   // Opcodes 000-101 are register-writing ALU operations
   function automatic logic is_alu_op(input logic [2:0] op);
      return op < OpLdSt;
   endfunction

endpackage

// File: rtl/stump_control_if.sv
// Memory handshake between the Stump control unit and the memory system.
interface stump_control_if;
   logic mem_ready;
   logic mem_ren;
   logic mem_wen;
   logic addr_sel;

   modport master (
      input  mem_ready,
      output mem_ren,
      output mem_wen,
      output addr_sel
   );

   modport slave (
      output mem_ready,
      input  mem_ren,
      input  mem_wen,
      input  addr_sel
   );
endinterface

// File: rtl/stump_cond_eval.sv
// Branch condition evaluator: decides whether a Bcc is taken given the current flags.
module stump_cond_eval
   import stump_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] cc,
   output logic       taken
);

   logic n, z, v, c;
   assign {n, z, v, c} = cc;

   // Decode the 16 condition codes against {N,Z,V,C}
   always_comb begin
      taken = 1'b0;
      unique case (cond)
         CondAl: taken = 1'b1;
         CondNv: taken = 1'b0;
         CondHi: taken = ~c & ~z;
         CondLs: taken = c | z;
         CondCc: taken = ~c;
         CondCs: taken = c;
         CondNe: taken = ~z;
         CondEq: taken = z;
         CondVc: taken = ~v;
         CondVs: taken = v;
         CondPl: taken = ~n;
         CondMi: taken = n;
         CondGe: taken = (n == v);
         CondLt: taken = (n != v);
         CondGt: taken = ~z & (n == v);
         CondLe: taken = z | (n != v);
      endcase
   end

endmodule

// File: rtl/stump_control.sv
// Stump processor control unit: FETCH / EXECUTE / MEMORY sequencer and condition-code register.
module stump_control
   import stump_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   stump_control_if.master        bus,
   input  logic [15:0]            ir,
   input  logic [3:0]             flags_in,
   output logic [1:0]             state,
   output logic                   ir_en,
   output logic                   pc_inc,
   output logic                   reg_we,
   output logic [2:0]             dest,
   output logic [2:0]             alu_func,
   output logic                   alu_c_in,
   output logic [1:0]             shift_op,
   output logic                   imm_sel,
   output logic [3:0]             cc
);

   logic [1:0] state_q, state_d;
   logic [3:0] cc_q, cc_d;
   logic       mem_ren, mem_wen, addr_sel;
   logic       taken;

   logic [2:0] opcode;
   logic       is_store;
   logic       unused_ir;

   assign opcode   = ir[15:13];
   assign is_store = ir[11];
   // Register source fields are consumed by the datapath, not by control
   assign unused_ir = ^ir[7:2];

   stump_cond_eval u_cond_eval (
      .cond  (ir[11:8]),
      .cc    (cc_q),
      .taken (taken)
   );

   // State and condition-code registers; reset is asynchronous
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
         cc_q    <= 4'b0000;
      end else begin
         state_q <= state_d;
         cc_q    <= cc_d;
      end
   end

   // Next-state, cc update and all control outputs from current state and ir
   always_comb begin
      state_d  = state_q;
      cc_d     = cc_q;
      ir_en    = 1'b0;
      pc_inc   = 1'b0;
      addr_sel = 1'b0;
      mem_ren  = 1'b0;
      mem_wen  = 1'b0;
      reg_we   = 1'b0;
      dest     = 3'b000;
      alu_func = 3'b000;
      alu_c_in = 1'b0;
      shift_op = 2'b00;
      imm_sel  = 1'b0;

      case (state_q)
         StFetch: begin
            mem_ren = 1'b1;
            if (bus.mem_ready) begin
               ir_en   = 1'b1;
               pc_inc  = 1'b1;
               state_d = StExecute;
            end
         end

         StExecute: begin
            // LD/ST and Bcc use ADD to form address / branch target
            alu_func = is_alu_op(opcode) ? opcode : OpAdd;
            alu_c_in = cc_q[0];
            imm_sel  = ir[12];
            shift_op = ir[12] ? 2'b00 : ir[1:0];
            state_d  = StFetch;
            if (is_alu_op(opcode)) begin
               reg_we = 1'b1;
               dest   = ir[10:8];
               if (ir[11]) begin
                  cc_d = flags_in;
               end
            end else if (opcode == OpLdSt) begin
               state_d = StMemory;
            end else if (taken) begin
               reg_we = 1'b1;
               dest   = 3'b111;
            end
         end

         StMemory: begin
            addr_sel = 1'b1;
            if (is_store) begin
               mem_wen = 1'b1;
            end else begin
               mem_ren = 1'b1;
            end
            if (bus.mem_ready) begin
               state_d = StFetch;
               if (!is_store) begin
                  reg_we = 1'b1;
                  dest   = ir[10:8];
               end
            end
         end

         default: begin
            state_d = StFetch;
         end
      endcase

      // Suppress every strobe while reset is held, even though FETCH is forced
      if (rst) begin
         ir_en   = 1'b0;
         pc_inc  = 1'b0;
         mem_ren = 1'b0;
         mem_wen = 1'b0;
         reg_we  = 1'b0;
      end
   end

   assign bus.mem_ren  = mem_ren;
   assign bus.mem_wen  = mem_wen;
   assign bus.addr_sel = addr_sel;
   assign state        = state_q;
   assign cc           = cc_q;

endmodule

// File: doc/stump_control.md
STUMP_CONTROL -- requirements
Module: stump_control

Interface
REQ-001 SHALL have no parameters; all widths are fixed by the Stump ISA.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ir  input  16  datapath instruction register; valid in EXECUTE and MEMORY.
REQ-005 flags_in  input  4  ALU flags {N,Z,V,C}, combinational from current ALU operation.
REQ-006 mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-007 state  output  2  FETCH=00, EXECUTE=01, MEMORY=10.
REQ-008 ir_en  output  1  load instruction register from memory read data.
REQ-009 pc_inc  output  1  increment PC (R7) by 1.
REQ-010 addr_sel  output  1  memory address: 0=PC, 1=address latch (ALU result captured in EXECUTE).
REQ-011 mem_ren / mem_wen  output  1 each  memory read / write strobe.
REQ-012 reg_we  output  1  register file write enable.
REQ-013 dest  output  3  register file write index.
REQ-014 alu_func  output  3  ALU function code.
REQ-015 alu_c_in  output  1  ALU carry input.
REQ-016 shift_op  output  2  shifter operation.
REQ-017 imm_sel  output  1  operand B source: 0=register, 1=sign-extended immediate.
REQ-018 cc  output  4  condition-code register {N,Z,V,C}.

Function
REQ-019 SHALL decode ir: [15:13] opcode, [12] type, [11] S (ALU ops) or L/S (1=store), [10:8] dest, [7:5] srcA, [4:2] srcB, [1:0] shift; Bcc uses [11:8] cond and [7:0] offset.
REQ-020 FETCH: mem_ren=1, addr_sel=0; hold while mem_ready=0; on mem_ready=1 assert ir_en and pc_inc for that cycle and go to EXECUTE.
REQ-021 EXECUTE takes exactly one cycle; alu_func=opcode for 000-101, 000 (ADD) for LD/ST and Bcc; alu_c_in=cc[0]; imm_sel=ir[12]; shift_op=ir[1:0] when ir[12]=0, else 00.
REQ-022 EXECUTE with opcode 000-101: reg_we=1, dest=ir[10:8]; next FETCH.
REQ-023 EXECUTE with S=1 and opcode 000-101: cc loads flags_in at end of cycle; S=0 leaves cc unchanged.
REQ-024 LD/ST and Bcc SHALL never modify cc.
REQ-025 EXECUTE with opcode 110: capture address, go to MEMORY; no reg_we.
REQ-026 EXECUTE with opcode 111: evaluate cond against cc; if true reg_we=1, dest=3'b111; if false no write; next FETCH.
REQ-027 Conditions 0-F: AL, NV, HI(~C&~Z), LS(C|Z), CC(~C), CS(C), NE(~Z), EQ(Z), VC(~V), VS(V), PL(~N), MI(N), GE(N==V), LT(N!=V), GT(~Z&N==V), LE(Z|N!=V).
REQ-028 MEMORY: addr_sel=1; load asserts mem_ren, store asserts mem_wen, held stable until mem_ready=1.
REQ-029 MEMORY load: reg_we=1, dest=ir[10:8] only in the cycle mem_ready=1; store: reg_we=0 throughout.
REQ-030 MEMORY exits to FETCH in the cycle after mem_ready=1; no limit on wait cycles.
REQ-031 mem_ren and mem_wen SHALL never be high together; all outputs not named active in a state SHALL be 0.
REQ-032 Unencoded state 11 SHALL return to FETCH on the next edge, all strobes 0.

Reset
REQ-033 rst=1 forces state=FETCH and cc=4'b0000 immediately, independent of clk.
REQ-034 During rst all strobes (ir_en, pc_inc, mem_ren, mem_wen, reg_we) SHALL be 0.
REQ-035 Reset mid-MEMORY SHALL abandon the access with no register write; first post-reset cycle is FETCH.

Structure
REQ-036 Opcode values, state encodings and condition codes SHALL live in shared package stump_pkg, also used by the ALU.
REQ-037 Condition evaluation SHALL be sub-module stump_cond_eval (inputs cond, cc; output taken); the rest is single-module FSM.

Verification
REQ-038 Reset: rst pulse mid-cycle -> state=00, cc=0000, all strobes 0 before next clk edge.
REQ-039 ADDS: mem_ready=1, ir=16'h094C, flags_in=4'b0100 -> FETCH 1 cycle, EXECUTE reg_we=1 dest=001 alu_func=000, cc=0100 after.
REQ-040 BEQ: cc=0100, ir=16'hF704 -> reg_we=1 dest=111; repeat with cc=0000 -> reg_we=0, cc unchanged.
REQ-041 LD with waits: ir=16'hD223, mem_ready low 2 cycles in MEMORY -> mem_ren=1, addr_sel=1 for 3 cycles, reg_we=1 dest=010 only in third, then FETCH.
REQ-042 ST: ir=16'hDA23 -> mem_wen=1, mem_ren=0, reg_we=0 in MEMORY; cc unchanged.
REQ-043 Reset during MEMORY wait (ir=16'hD223, mem_ready=0) -> no reg_we, state=00 immediately.
